csa_bulk_fifo: RTL and testbench

CSA_BULK_FIFO -- requirements
Module: csa_bulk_fifo

---
 rtl/csa_bulk_fifo.sv | 178 +++++++++++++++++
 tb/tb_csa_bulk_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_bulk_fifo.sv
// Bulk FIFO: words are written and read one per cycle, but become visible to the
// reader only once a whole bulk of BULK_OF_DATA words has been committed. Optional
// sequence checking compares word 0 of each committed bulk with the previous one + 1.
module csa_bulk_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BULK_OF_DATA = 7,
    parameter int unsigned BULK_DEPTH   = 16,
    parameter int unsigned SEQ_CHECK    = 1
) (
    input  logic                          axi_mm_clk,
    input  logic                          rst_n,
    input  logic                          w_enable,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          w_abort,
    output logic                          w_ready,
    input  logic                          r_enable,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          r_ready,
    output logic [$clog2(BULK_DEPTH):0]   bulk_count,
    output logic                          error_full,
    output logic                          error_empty,
    output logic                          seq_error,
    output logic [31:0]                   seq_error_count
);

    localparam int unsigned OW    = $clog2(BULK_OF_DATA);
    localparam int unsigned BW    = $clog2(BULK_DEPTH);
    localparam int unsigned CW    = BW + 1;
    localparam int unsigned Words = BULK_DEPTH * BULK_OF_DATA;
    localparam int unsigned AW    = $clog2(Words);

    logic [DATA_WIDTH-1:0] mem_q [Words];

    logic [BW-1:0]         wr_bulk_q, wr_bulk_d;
    logic [OW-1:0]         wr_off_q, wr_off_d;
    logic [BW-1:0]         rd_bulk_q, rd_bulk_d;
    logic [OW-1:0]         rd_off_q, rd_off_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_full_q, err_full_d;
    logic                  err_empty_q, err_empty_d;
    logic                  seq_err_q, seq_err_d;
    logic [31:0]           seq_cnt_q, seq_cnt_d;
    logic [DATA_WIDTH-1:0] word0_q, word0_d;
    logic [DATA_WIDTH-1:0] ref_q, ref_d;
    logic                  ref_valid_q, ref_valid_d;

    logic          wr_go, wr_last, commit;
    logic          rd_go, rd_last, rel;
    logic [AW-1:0] wr_addr, rd_addr;

    assign w_ready         = (count_q < CW'(BULK_DEPTH));
    assign r_ready         = (count_q != '0);
    assign bulk_count      = count_q;
    assign rdata           = rdata_q;
    assign error_full      = err_full_q;
    assign error_empty     = err_empty_q;
    assign seq_error       = seq_err_q;
    assign seq_error_count = seq_cnt_q;

    // Decode this cycle's write/read actions and the flat memory addresses
    always_comb begin
        // Abort wins over a same-cycle write and suppresses the full error
        wr_go   = w_enable && w_ready && !w_abort;
        wr_last = (wr_off_q == OW'(BULK_OF_DATA - 1));
        commit  = wr_go && wr_last;
        rd_go   = r_enable && r_ready;
        rd_last = (rd_off_q == OW'(BULK_OF_DATA - 1));
        rel     = rd_go && rd_last;
        wr_addr = AW'(wr_bulk_q) * AW'(BULK_OF_DATA) + AW'(wr_off_q);
        rd_addr = AW'(rd_bulk_q) * AW'(BULK_OF_DATA) + AW'(rd_off_q);
    end

    // Next-state for pointers, occupancy, read data and error pulses
    always_comb begin
        wr_bulk_d   = wr_bulk_q;
        wr_off_d    = wr_off_q;
        rd_bulk_d   = rd_bulk_q;
        rd_off_d    = rd_off_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        err_full_d  = w_enable && !w_ready && !w_abort;
        err_empty_d = r_enable && !r_ready;

        if (w_abort) begin
            wr_off_d = '0;
        end else if (wr_go) begin
            if (wr_last) begin
                wr_off_d  = '0;
                wr_bulk_d = wr_bulk_q + 1'b1;  // BULK_DEPTH is a power of two
            end else begin
                wr_off_d = wr_off_q + 1'b1;
            end
        end

        if (rd_go) begin
            rdata_d = mem_q[rd_addr];
            if (rd_last) begin
                rd_off_d  = '0;
                rd_bulk_d = rd_bulk_q + 1'b1;
            end else begin
                rd_off_d = rd_off_q + 1'b1;
            end
        end

        case ({commit, rel})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next-state for the word-0 sequence checker; inert when SEQ_CHECK is 0
    always_comb begin
        word0_d     = word0_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        seq_err_d   = 1'b0;
        seq_cnt_d   = seq_cnt_q;
        if (SEQ_CHECK != 0) begin
            if (wr_go && (wr_off_q == '0)) begin
                word0_d = wdata;
            end
            // Only committed bulks move the reference, so aborted bulks are ignored
            if (commit) begin
                ref_d       = word0_q;
                ref_valid_d = 1'b1;
                if (ref_valid_q && (word0_q != ref_q + DATA_WIDTH'(1))) begin
                    seq_err_d = 1'b1;
                    if (seq_cnt_q != 32'hFFFF_FFFF) begin
                        seq_cnt_d = seq_cnt_q + 32'd1;
                    end
                end
            end
        end
    end

    // Control and status registers, cleared asynchronously
    always_ff @(posedge axi_mm_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bulk_q   <= '0;
            wr_off_q    <= '0;
            rd_bulk_q   <= '0;
            rd_off_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
            seq_err_q   <= 1'b0;
            seq_cnt_q   <= '0;
            word0_q     <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
        end else begin
            wr_bulk_q   <= wr_bulk_d;
            wr_off_q    <= wr_off_d;
            rd_bulk_q   <= rd_bulk_d;
            rd_off_q    <= rd_off_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
            seq_err_q   <= seq_err_d;
            seq_cnt_q   <= seq_cnt_d;
            word0_q     <= word0_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
        end
    end

    // Data storage; contents survive reset since pointers make them unreachable
    always_ff @(posedge axi_mm_clk) begin
        if (wr_go) begin
            mem_q[wr_addr] <= wdata;
        end
    end

endmodule

// File: tb/tb_csa_bulk_fifo.sv
// Self-checking bench for csa_bulk_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of bulk commit/release.
module tb_csa_bulk_fifo;

    localparam int DW = 32;
    localparam int B  = 7;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_enable = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          w_abort = 1'b0;
    logic          w_ready;
    logic          r_enable = 1'b0;
    logic [DW-1:0] rdata;
    logic          r_ready;
    logic [4:0]    bulk_count;
    logic          error_full;
    logic          error_empty;
    logic          seq_error;
    logic [31:0]   seq_error_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] cq[$];    // readable words of committed, unreleased bulks
    logic [DW-1:0] pq[$];    // words of the bulk being written
    int            m_count;
    int            m_roff;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_ref;
    bit            m_refv;
    logic [31:0]   m_seqcnt;
    bit            e_full, e_empty, e_seq;

    csa_bulk_fifo #(
        .DATA_WIDTH  (DW),
        .BULK_OF_DATA(B),
        .BULK_DEPTH  (D),
        .SEQ_CHECK   (1)
    ) dut (
        .axi_mm_clk     (clk),
        .rst_n          (rst_n),
        .w_enable       (w_enable),
        .wdata          (wdata),
        .w_abort        (w_abort),
        .w_ready        (w_ready),
        .r_enable       (r_enable),
        .rdata          (rdata),
        .r_ready        (r_ready),
        .bulk_count     (bulk_count),
        .error_full     (error_full),
        .error_empty    (error_empty),
        .seq_error      (seq_error),
        .seq_error_count(seq_error_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cq.delete();
        pq.delete();
        m_count  = 0;
        m_roff   = 0;
        m_rdata  = '0;
        m_ref    = '0;
        m_refv   = 0;
        m_seqcnt = '0;
        e_full   = 0;
        e_empty  = 0;
        e_seq    = 0;
    endtask

    task automatic check_all();
        chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("bulk_count", 64'(bulk_count), 64'(m_count));
        chk("r_ready", 64'(r_ready), 64'(m_count != 0));
        chk("w_ready", 64'(w_ready), 64'(m_count < D));
        chk("error_full", 64'(error_full), 64'(e_full));
        chk("error_empty", 64'(error_empty), 64'(e_empty));
        chk("seq_error", 64'(seq_error), 64'(e_seq));
        chk("seq_error_count", 64'(seq_error_count), 64'(m_seqcnt));
    endtask

    // One clock: drive inputs, advance the model, check all outputs after the edge
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit wa, input bit re);
        int old;
        bit c;
        bit r;
        old = m_count;
        c = 0;
        r = 0;
        w_enable = we;
        wdata    = wd;
        w_abort  = wa;
        r_enable = re;
        e_full  = 0;
        e_empty = 0;
        e_seq   = 0;
        if (wa) begin
            pq.delete();
        end else if (we) begin
            if (old < D) begin
                pq.push_back(wd);
                if (pq.size() == B) begin
                    if (m_refv && (pq[0] != m_ref + 1)) begin
                        e_seq = 1;
                        if (m_seqcnt != 32'hFFFF_FFFF) m_seqcnt++;
                    end
                    m_ref  = pq[0];
                    m_refv = 1;
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                    c = 1;
                end
            end else begin
                e_full = 1;
            end
        end
        if (re) begin
            if (old != 0) begin
                m_rdata = cq.pop_front();
                m_roff++;
                if (m_roff == B) begin
                    m_roff = 0;
                    r = 1;
                end
            end else begin
                e_empty = 1;
            end
        end
        m_count = old + int'(c) - int'(r);
        @(posedge clk);
        #1;
        w_enable = 0;
        w_abort  = 0;
        r_enable = 0;
        check_all();
    endtask

    task automatic write_bulk(input logic [DW-1:0] first);
        step(1, first, 0, 0);
        for (int i = 1; i < B; i++) step(1, first * 32'd100 + DW'(i), 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        #2;
        w_enable = 0;
        w_abort  = 0;
        r_enable = 0;
        rst_n    = 0;
        #1;
        model_reset();
        chk("rst_bulk_count", 64'(bulk_count), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd1);
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] held;
        bit            we, re, wa;
        logic [DW-1:0] wd;

        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_all();

        // Single bulk 1..7 written then read back
        for (int i = 1; i <= B; i++) step(1, DW'(i), 0, 0);
        chk("commit_r_ready", 64'(r_ready), 64'd1);
        chk("commit_count", 64'(bulk_count), 64'd1);
        for (int i = 1; i <= B; i++) begin
            step(0, 0, 0, 1);
            chk("read_seq_word", 64'(rdata), 64'(i));
        end
        chk("drain_count", 64'(bulk_count), 64'd0);

        // Read while empty: error pulse, rdata held
        held = rdata;
        step(0, 0, 0, 1);
        chk("empty_pulse", 64'(error_empty), 64'd1);
        chk("empty_rdata_held", 64'(rdata), 64'(held));

        // Sequence checking from a fresh reference: 1,2,4,5
        do_reset();
        write_bulk(1);
        write_bulk(2);
        write_bulk(4);
        chk("seq_pulse", 64'(seq_error), 64'd1);
        write_bulk(5);
        chk("seq_count", 64'(seq_error_count), 64'd1);

        // Fill to 16 bulks, then one more word is dropped
        for (int b = 6; b < 18; b++) write_bulk(DW'(b));
        chk("full_w_ready", 64'(w_ready), 64'd0);
        step(1, 32'hDEAD_BEEF, 0, 0);
        chk("full_pulse", 64'(error_full), 64'd1);
        step(0, 0, 0, 0);
        for (int i = 0; i < D * B; i++) step(0, 0, 0, 1);
        chk("full_drained", 64'(bulk_count), 64'd0);

        // Partial bulk aborted; abort also beats a same-cycle write
        for (int i = 0; i < 3; i++) step(1, 32'h0000_0A00 + DW'(i), 0, 0);
        step(0, 0, 1, 0);
        step(1, 32'h0000_0B00, 0, 0);
        step(1, 32'h0000_0B01, 1, 0);
        chk("abort_no_full", 64'(error_full), 64'd0);
        write_bulk(18);
        for (int i = 0; i < B; i++) step(0, 0, 0, 1);
        chk("abort_only_bulk", 64'(bulk_count), 64'd0);

        // Last-word write and last-word read on the same edge
        write_bulk(19);
        for (int i = 0; i < B - 1; i++) step(0, 0, 0, 1);
        step(1, 20, 0, 0);
        for (int i = 1; i < B - 1; i++) step(1, DW'(2000 + i), 0, 0);
        step(1, 32'd2006, 0, 1);
        chk("same_edge_count", 64'(bulk_count), 64'd1);
        for (int i = 0; i < B; i++) step(0, 0, 0, 1);

        // Random traffic: write-heavy phase then read-heavy phase
        for (int n = 0; n < 3000; n++) begin
            if (n < 1500) begin
                we = ($urandom % 10) < 8;
                re = ($urandom % 10) < 3;
            end else begin
                we = ($urandom % 10) < 3;
                re = ($urandom % 10) < 8;
            end
            wa = ($urandom % 60) == 0;
            if (pq.size() == 0 && m_refv && ($urandom % 8) != 0) wd = m_ref + 1;
            else wd = $urandom;
            step(we, wd, wa, re);
        end

        // Reset mid-bulk with two bulks committed
        do_reset();
        write_bulk(30);
        write_bulk(31);
        for (int i = 0; i < 3; i++) step(1, DW'(i), 0, 0);
        chk("pre_reset_count", 64'(bulk_count), 64'd2);
        do_reset();
        step(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
